// File: rtl/hs32_fetch.sv
`default_nettype none
// ============================================================================
// Module      : hs32_fetch
// Description : Instruction fetch unit. Issues word reads, buffers returned
//               words with their PC in a prefetch FIFO, serves decode.
// Revision    : 1.0 - initial release
// ============================================================================
module hs32_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instd,
    output logic [31:0] instpc,
    output logic        ackd,
    input  logic        reqd,
    input  logic        flush,
    input  logic [31:0] newpc,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_nxt;
    logic [31:0]       r_mem_addr;
    logic [31:0]       w_addr_nxt;
    logic [c_CW-1:0]   r_count;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW-1:0]   r_wptr;
    logic [31:0]       r_instd;
    logic [31:0]       r_instpc;
    logic [31:0]       r_fifo_data [DEPTH];
    logic [31:0]       r_fifo_pc   [DEPTH];

    logic              w_pop;
    logic              w_push;
    logic [c_CW-1:0]   w_count_nxt;
    logic [c_CW-1:0]   w_remain;
    logic [c_AW-1:0]   w_rd_idx;
    logic [31:0]       w_pc_inc;
    logic [31:0]       w_newpc_al;
    logic [31:0]       w_head_data;
    logic [31:0]       w_head_pc;

    assign w_pop       = reqd & (r_count != '0) & ~flush;
    assign w_push      = (r_state == S_REQ) & mem_ack & ~flush;
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_remain    = r_count - c_CW'(w_pop);
    assign w_rd_idx    = r_rptr + c_AW'(w_pop);
    assign w_pc_inc    = r_pc + 32'd4;
    assign w_newpc_al  = newpc & ~32'h0000_0003;

    assign instd    = r_instd;
    assign instpc   = r_instpc;
    assign ackd     = (r_count != '0);
    assign mem_addr = r_mem_addr;
    assign mem_req  = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_mem_addr;
        if (flush) begin
            w_pc_nxt = w_newpc_al;
            case (r_state)
                // An ack in the flush cycle retires the stale request outright.
                S_REQ:   w_state_nxt = mem_ack ? S_IDLE : S_DROP;
                S_DROP:  w_state_nxt = mem_ack ? S_IDLE : S_DROP;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < c_DEPTH) begin
                        w_state_nxt = S_REQ;
                        w_addr_nxt  = r_pc;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        w_pc_nxt = w_pc_inc;
                        if (w_count_nxt < c_DEPTH) begin
                            w_addr_nxt = w_pc_inc;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Head registers track the entry that will be at the FIFO front after this edge.
    always_comb begin
        w_head_data = r_instd;
        w_head_pc   = r_instpc;
        if (!flush) begin
            if (w_remain == '0) begin
                if (w_push) begin
                    w_head_data = mem_data;
                    w_head_pc   = r_pc;
                end
            end else begin
                w_head_data = r_fifo_data[w_rd_idx];
                w_head_pc   = r_fifo_pc[w_rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= {RESET_VEC[31:2], 2'b00};
            r_mem_addr <= '0;
            r_count    <= '0;
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_instd    <= '0;
            r_instpc   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_mem_addr <= w_addr_nxt;
            r_instd    <= w_head_data;
            r_instpc   <= w_head_pc;
            if (flush) begin
                r_count <= '0;
                r_rptr  <= '0;
                r_wptr  <= '0;
            end else begin
                r_count <= w_count_nxt;
                if (w_push) begin
                    r_wptr <= r_wptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= mem_data;
            r_fifo_pc[r_wptr]   <= r_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs32_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs32_fetch
// Description : Self-checking bench for hs32_fetch with a memory responder
//               and an in-order instruction-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs32_fetch;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam int          DEPTH     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instd;
    logic [31:0] instpc;
    logic        ackd;
    logic        reqd;
    logic        flush;
    logic [31:0] newpc;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    hs32_fetch #(.RESET_VEC(RESET_VEC), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .instd    (instd),
        .instpc   (instpc),
        .ackd     (ackd),
        .reqd     (reqd),
        .flush    (flush),
        .newpc    (newpc),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory responder: acks after lat_mode idle cycles (random 0..3 if negative)
    bit          mem_en = 1'b0;
    int          lat_mode = 1;
    bit          pending = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] req_addr = '0;
    logic [31:0] acc_q [$];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mem_en) begin
                if (reset === 1'b1 && mem_req === 1'b1) begin
                    if (!pending) begin
                        pending  = 1'b1;
                        req_addr = mem_addr;
                        wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    end else begin
                        n_checks++;
                        if (mem_addr !== req_addr)
                            $display("FAIL mem_addr_stable: got %h expected %h", mem_addr, req_addr);
                        else
                            n_pass++;
                    end
                    if (wait_cnt == 0) begin
                        mem_ack  = 1'b1;
                        mem_data = memf(mem_addr);
                        pending  = 1'b0;
                        acc_q.push_back(mem_addr);
                    end else begin
                        mem_ack  = 1'b0;
                        wait_cnt = wait_cnt - 1;
                    end
                end else begin
                    mem_ack = 1'b0;
                    pending = 1'b0;
                end
            end else begin
                pending = 1'b0;
            end
        end
    end

    // Reference model: decode must see consecutive PCs from the last reset/flush target
    logic [31:0] exp_pc = RESET_VEC;
    logic [31:0] xfer_q [$];
    int          n_xfer = 0;
    bit          last_kill = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (last_kill) begin
                n_checks++;
                if (ackd !== 1'b0)
                    $display("FAIL ackd_after_kill: got %b expected 0", ackd);
                else
                    n_pass++;
            end
            if (reset !== 1'b1) begin
                exp_pc = RESET_VEC;
            end else if (flush === 1'b1) begin
                exp_pc = newpc & ~32'h3;
            end else if (reqd === 1'b1 && ackd === 1'b1) begin
                n_checks++;
                if (instpc !== exp_pc)
                    $display("FAIL xfer_pc: got %h expected %h", instpc, exp_pc);
                else
                    n_pass++;
                n_checks++;
                if (instd !== memf(exp_pc))
                    $display("FAIL xfer_data: got %h expected %h", instd, memf(exp_pc));
                else
                    n_pass++;
                xfer_q.push_back(instpc);
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            last_kill = (reset !== 1'b1) || (flush === 1'b1);
        end
    end

    task automatic begin_run();
        reset   = 1'b0;
        flush   = 1'b0;
        mem_ack = 1'b0;
        tick(2);
        acc_q.delete();
        xfer_q.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        mem_en = 1'b0;
        reset  = 1'b0;
        tick(2);
        n_checks++; if (ackd !== 1'b0) $display("FAIL rst_ackd: got %b expected 0", ackd); else n_pass++;
        n_checks++; if (instd !== 32'h0) $display("FAIL rst_instd: got %h expected 0", instd); else n_pass++;
        n_checks++; if (instpc !== 32'h0) $display("FAIL rst_instpc: got %h expected 0", instpc); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); else n_pass++;
    endtask

    task automatic test_stream();
        mem_en   = 1'b1;
        lat_mode = 1;
        reqd     = 1'b1;
        begin_run();
        tick(20);
        n_checks++;
        if (acc_q.size() < 3)
            $display("FAIL stream_addr_count: got %0d expected >=3", acc_q.size());
        else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4 || acc_q[2] !== 32'h8)
            $display("FAIL stream_addr: got %h %h %h expected 0 4 8", acc_q[0], acc_q[1], acc_q[2]);
        else
            n_pass++;
        n_checks++;
        if (xfer_q.size() < 3)
            $display("FAIL stream_pc_count: got %0d expected >=3", xfer_q.size());
        else if (xfer_q[0] !== 32'h0 || xfer_q[1] !== 32'h4 || xfer_q[2] !== 32'h8)
            $display("FAIL stream_pc: got %h %h %h expected 0 4 8", xfer_q[0], xfer_q[1], xfer_q[2]);
        else
            n_pass++;
    endtask

    task automatic test_full();
        mem_en   = 1'b1;
        lat_mode = 0;
        reqd     = 1'b0;
        begin_run();
        tick(10);
        n_checks++;
        if (acc_q.size() != DEPTH)
            $display("FAIL full_fetch_count: got %0d expected %0d", acc_q.size(), DEPTH);
        else if (acc_q[0] !== 32'h0 || acc_q[1] !== 32'h4)
            $display("FAIL full_fetch_addr: got %h %h expected 0 4", acc_q[0], acc_q[1]);
        else
            n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL full_mem_req: got %b expected 0", mem_req); else n_pass++;
        n_checks++; if (ackd !== 1'b1) $display("FAIL full_ackd: got %b expected 1", ackd); else n_pass++;
        n_checks++; if (instd !== memf(32'h0)) $display("FAIL full_instd: got %h expected %h", instd, memf(32'h0)); else n_pass++;
        reqd = 1'b1;
        tick();
        reqd = 1'b0;
        tick(6);
        n_checks++;
        if (acc_q.size() != 3)
            $display("FAIL refill_count: got %0d expected 3", acc_q.size());
        else if (acc_q[2] !== 32'h8)
            $display("FAIL refill_addr: got %h expected 8", acc_q[2]);
        else
            n_pass++;
        n_checks++; if (instpc !== 32'h4) $display("FAIL refill_head: got %h expected 4", instpc); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL refill_mem_req: got %b expected 0", mem_req); else n_pass++;
    endtask

    task automatic test_flush_drop();
        mem_en = 1'b0;
        reqd   = 1'b1;
        begin_run();
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL drop_issue: got %b/%h expected 1/0", mem_req, mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_data = memf(32'h0);
        tick();
        mem_ack = 1'b0;
        n_checks++; if (ackd !== 1'b1 || instpc !== 32'h0) $display("FAIL latency: got %b/%h expected 1/0", ackd, instpc); else n_pass++;
        n_checks++; if (mem_addr !== 32'h4) $display("FAIL b2b_addr: got %h expected 4", mem_addr); else n_pass++;
        tick();
        mem_ack = 1'b1; mem_data = memf(32'h4);
        tick();
        mem_ack = 1'b0;
        flush = 1'b1; newpc = 32'h0000_0103;
        tick();
        flush = 1'b0;
        n_checks++; if (ackd !== 1'b0) $display("FAIL drop_ackd: got %b expected 0", ackd); else n_pass++;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) $display("FAIL drop_hold: got %b/%h expected 1/8", mem_req, mem_addr); else n_pass++;
        tick(2);
        mem_ack = 1'b1; mem_data = memf(32'h8);
        tick();
        mem_ack = 1'b0;
        n_checks++; if (ackd !== 1'b0 || mem_req !== 1'b0) $display("FAIL drop_discard: got %b/%b expected 0/0", ackd, mem_req); else n_pass++;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL redirect_addr: got %b/%h expected 1/100", mem_req, mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_data = memf(32'h100);
        tick();
        mem_ack = 1'b0;
        n_checks++; if (ackd !== 1'b1 || instpc !== 32'h100) $display("FAIL redirect_pc: got %b/%h expected 1/100", ackd, instpc); else n_pass++;
        reqd = 1'b0;
    endtask

    task automatic test_flush_ack();
        mem_en = 1'b0;
        reqd   = 1'b1;
        begin_run();
        tick();
        mem_ack = 1'b1; mem_data = memf(32'h0);
        tick();
        mem_ack = 1'b1; mem_data = memf(32'h4);
        flush = 1'b1; newpc = 32'h0000_2000;
        tick();
        mem_ack = 1'b0;
        flush   = 1'b0;
        n_checks++; if (ackd !== 1'b0 || mem_req !== 1'b0) $display("FAIL fack_state: got %b/%b expected 0/0", ackd, mem_req); else n_pass++;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) $display("FAIL fack_addr: got %b/%h expected 1/2000", mem_req, mem_addr); else n_pass++;
        n_checks++; if (ackd !== 1'b0) $display("FAIL fack_nopush: got %b expected 0", ackd); else n_pass++;
        mem_ack = 1'b1; mem_data = memf(32'h2000);
        tick();
        mem_ack = 1'b0;
        n_checks++; if (ackd !== 1'b1 || instpc !== 32'h2000) $display("FAIL fack_pc: got %b/%h expected 1/2000", ackd, instpc); else n_pass++;
        reqd = 1'b0;
    endtask

    task automatic test_wrap();
        mem_en   = 1'b1;
        lat_mode = 0;
        reqd     = 1'b1;
        reset    = 1'b0;
        flush    = 1'b0;
        mem_ack  = 1'b0;
        tick(2);
        reset = 1'b1;
        flush = 1'b1; newpc = 32'hFFFF_FFFE;
        tick();
        flush = 1'b0;
        acc_q.delete();
        xfer_q.delete();
        tick(8);
        n_checks++;
        if (acc_q.size() < 2)
            $display("FAIL wrap_addr_count: got %0d expected >=2", acc_q.size());
        else if (acc_q[0] !== 32'hFFFF_FFFC || acc_q[1] !== 32'h0)
            $display("FAIL wrap_addr: got %h %h expected fffffffc 0", acc_q[0], acc_q[1]);
        else
            n_pass++;
        n_checks++;
        if (xfer_q.size() < 2)
            $display("FAIL wrap_pc_count: got %0d expected >=2", xfer_q.size());
        else if (xfer_q[0] !== 32'hFFFF_FFFC || xfer_q[1] !== 32'h0)
            $display("FAIL wrap_pc: got %h %h expected fffffffc 0", xfer_q[0], xfer_q[1]);
        else
            n_pass++;
        reqd = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b0;
        reqd   = 1'b0;
        begin_run();
        tick();
        mem_ack = 1'b1; mem_data = memf(32'h0);
        tick();
        mem_ack = 1'b1; mem_data = memf(32'h4);
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || ackd !== 1'b0) $display("FAIL midrst_state: got %b/%b expected 0/0", mem_req, ackd); else n_pass++;
        n_checks++; if (instd !== 32'h0) $display("FAIL midrst_instd: got %h expected 0", instd); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== RESET_VEC) $display("FAIL midrst_restart: got %b/%h expected 1/%h", mem_req, mem_addr, RESET_VEC); else n_pass++;
    endtask

    task automatic test_random();
        int start_xfer;
        mem_en   = 1'b1;
        lat_mode = -1;
        begin_run();
        start_xfer = n_xfer;
        for (int i = 0; i < 3000; i++) begin
            reqd  = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            newpc = $urandom;
            reset = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1;
        flush = 1'b0;
        reqd  = 1'b1;
        tick(20);
        n_checks++;
        if (n_xfer - start_xfer < 200)
            $display("FAIL random_throughput: got %0d expected >=200", n_xfer - start_xfer);
        else
            n_pass++;
    endtask

    initial begin
        reset    = 1'b0;
        reqd     = 1'b0;
        flush    = 1'b0;
        newpc    = '0;
        mem_ack  = 1'b0;
        mem_data = '0;
        test_reset();
        test_stream();
        test_full();
        test_flush_drop();
        test_flush_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
